// File: rtl/axi_lite_param_regfile.sv
// AXI4-Lite slave register file with parametrised depth, reset values, byte strobes,
// read-only status words and per-register write pulses. Single clock domain.
module axi_lite_param_regfile #(
  parameter int unsigned               REG_COUNT    = 8,
  parameter int unsigned               ADDR_WIDTH   = 8,
  parameter logic [REG_COUNT-1:0]      RO_MASK      = '0,
  parameter logic [REG_COUNT*32-1:0]   RESET_VALUES = '0
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [ADDR_WIDTH-1:0]   s_axi_lite_awaddr,
  input  logic                    s_axi_lite_awvalid,
  output logic                    s_axi_lite_awready,
  input  logic [31:0]             s_axi_lite_wdata,
  input  logic [3:0]              s_axi_lite_wstrb,
  input  logic                    s_axi_lite_wvalid,
  output logic                    s_axi_lite_wready,
  output logic [1:0]              s_axi_lite_bresp,
  output logic                    s_axi_lite_bvalid,
  input  logic                    s_axi_lite_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_lite_araddr,
  input  logic                    s_axi_lite_arvalid,
  output logic                    s_axi_lite_arready,
  output logic [31:0]             s_axi_lite_rdata,
  output logic [1:0]              s_axi_lite_rresp,
  output logic                    s_axi_lite_rvalid,
  input  logic                    s_axi_lite_rready,
  output logic [REG_COUNT*32-1:0] regs_out,
  input  logic [REG_COUNT*32-1:0] status_in,
  output logic [REG_COUNT-1:0]    wr_pulse
);

  localparam int unsigned IDX_W  = ADDR_WIDTH - 2;
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;

  typedef enum logic [2:0] {W_IDLE, W_DATA, W_ADDR, W_EXEC, W_RESP} wr_state_e;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_RESP} rd_state_e;

  wr_state_e w_state_q, w_state_d;
  rd_state_e r_state_q, r_state_d;

  logic [IDX_W-1:0]       w_idx_q, r_idx_q;
  logic [31:0]            w_data_q;
  logic [3:0]             w_strb_q;
  logic [REG_COUNT*32-1:0] regs_q;
  logic [REG_COUNT-1:0]   w_sel;
  logic                   w_ok;
  logic [31:0]            r_word;
  logic                   r_hit;
  logic [1:0]             bresp_q, rresp_q;
  logic [31:0]            rdata_q;
  logic                   aw_hs, w_hs, ar_hs;

  // Byte-lane bits of the addresses never select anything.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = &{1'b0, s_axi_lite_awaddr[1:0], s_axi_lite_araddr[1:0]};

  assign aw_hs = s_axi_lite_awvalid && s_axi_lite_awready;
  assign w_hs  = s_axi_lite_wvalid  && s_axi_lite_wready;
  assign ar_hs = s_axi_lite_arvalid && s_axi_lite_arready;

  // ---------------- write channel ----------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state_q <= W_IDLE;
      w_idx_q   <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      w_state_q <= w_state_d;
      if (aw_hs) w_idx_q <= s_axi_lite_awaddr[ADDR_WIDTH-1:2];
      if (w_hs) begin
        w_data_q <= s_axi_lite_wdata;
        w_strb_q <= s_axi_lite_wstrb;
      end
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    w_state_d          = w_state_q;
    s_axi_lite_awready = 1'b0;
    s_axi_lite_wready  = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        s_axi_lite_awready = 1'b1;
        s_axi_lite_wready  = 1'b1;
        if (s_axi_lite_awvalid && s_axi_lite_wvalid) w_state_d = W_EXEC;
        else if (s_axi_lite_awvalid)                 w_state_d = W_DATA;
        else if (s_axi_lite_wvalid)                  w_state_d = W_ADDR;
      end
      W_DATA: begin
        s_axi_lite_wready = 1'b1;
        if (s_axi_lite_wvalid) w_state_d = W_EXEC;
      end
      W_ADDR: begin
        s_axi_lite_awready = 1'b1;
        if (s_axi_lite_awvalid) w_state_d = W_EXEC;
      end
      W_EXEC: w_state_d = W_RESP;
      W_RESP: if (s_axi_lite_bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  // Comparing the full index against each legal slot means out-of-range never aliases.
  always_comb begin
    w_sel = '0;
    for (int unsigned i = 0; i < REG_COUNT; i++)
      if (32'(w_idx_q) == i) w_sel[i] = 1'b1;
  end

  assign w_ok     = |(w_sel & ~RO_MASK);
  assign wr_pulse = (w_state_q == W_EXEC) ? (w_sel & ~RO_MASK) : '0;

  // NOTE: the register array is reset, unlike a RAM, because its reset contents are architectural.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      regs_q  <= RESET_VALUES;
      bresp_q <= OKAY;
    end else if (w_state_q == W_EXEC) begin
      bresp_q <= w_ok ? OKAY : SLVERR;
      for (int unsigned i = 0; i < REG_COUNT; i++)
        for (int unsigned k = 0; k < 4; k++)
          if (wr_pulse[i] && w_strb_q[k])
            regs_q[i*32 + k*8 +: 8] <= w_data_q[k*8 +: 8];
    end
  end

  assign regs_out          = regs_q;
  assign s_axi_lite_bresp  = bresp_q;
  assign s_axi_lite_bvalid = (w_state_q == W_RESP);

  // ---------------- read channel ----------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state_q <= R_IDLE;
      r_idx_q   <= '0;
      rdata_q   <= '0;
      rresp_q   <= OKAY;
    end else begin
      r_state_q <= r_state_d;
      if (ar_hs) r_idx_q <= s_axi_lite_araddr[ADDR_WIDTH-1:2];
      if (r_state_q == R_FETCH) begin
        rdata_q <= r_word;
        rresp_q <= r_hit ? OKAY : SLVERR;
      end
    end
  end

  always_comb begin
    r_state_d          = r_state_q;
    s_axi_lite_arready = 1'b0;
    unique case (r_state_q)
      R_IDLE: begin
        s_axi_lite_arready = 1'b1;
        if (s_axi_lite_arvalid) r_state_d = R_FETCH;
      end
      R_FETCH: r_state_d = R_RESP;
      R_RESP:  if (s_axi_lite_rready) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // Stored value of the addressed word is the pre-write value if a write executes this cycle.
  always_comb begin
    r_word = '0;
    r_hit  = 1'b0;
    for (int unsigned i = 0; i < REG_COUNT; i++)
      if (32'(r_idx_q) == i) begin
        r_hit  = 1'b1;
        r_word = RO_MASK[i] ? status_in[i*32 +: 32] : regs_q[i*32 +: 32];
      end
  end

  assign s_axi_lite_rdata  = rdata_q;
  assign s_axi_lite_rresp  = rresp_q;
  assign s_axi_lite_rvalid = (r_state_q == R_RESP);

endmodule

// File: tb/tb_axi_lite_param_regfile.sv
// Directed bench for axi_lite_param_regfile: 8 registers, word 7 read-only status,
// distinct reset values so restores and non-updates are visible.
module tb_axi_lite_param_regfile;

  localparam int unsigned REG_COUNT = 8;
  localparam logic [255:0] RST_VALS = {32'h1000_0007, 32'h1000_0006, 32'h1000_0005,
                                       32'h1000_0004, 32'h1000_0003, 32'h1122_3344,
                                       32'h1000_0001, 32'h1000_0000};

  logic         aclk, aresetn;
  logic [7:0]   awaddr, araddr;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rvalid, rready;
  logic [31:0]  wdata, rdata;
  logic [3:0]   wstrb;
  logic [1:0]   bresp, rresp;
  logic [255:0] regs_out, status_in;
  logic [7:0]   wr_pulse;

  logic [255:0] exp_regs;
  int n_checks = 0;
  int n_fail   = 0;

  axi_lite_param_regfile #(
    .REG_COUNT(REG_COUNT), .ADDR_WIDTH(8), .RO_MASK(8'h80), .RESET_VALUES(RST_VALS)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axi_lite_awaddr(awaddr), .s_axi_lite_awvalid(awvalid), .s_axi_lite_awready(awready),
    .s_axi_lite_wdata(wdata), .s_axi_lite_wstrb(wstrb), .s_axi_lite_wvalid(wvalid),
    .s_axi_lite_wready(wready), .s_axi_lite_bresp(bresp), .s_axi_lite_bvalid(bvalid),
    .s_axi_lite_bready(bready), .s_axi_lite_araddr(araddr), .s_axi_lite_arvalid(arvalid),
    .s_axi_lite_arready(arready), .s_axi_lite_rdata(rdata), .s_axi_lite_rresp(rresp),
    .s_axi_lite_rvalid(rvalid), .s_axi_lite_rready(rready),
    .regs_out(regs_out), .status_in(status_in), .wr_pulse(wr_pulse)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Drives AW and W together, collects any write pulses, returns BRESP.
  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp, output logic [7:0] pulses, output bit timeout);
    bit aw_done = 1'b0;
    bit w_done  = 1'b0;
    bit aw_hs, w_hs;
    int cyc = 0;
    pulses = '0; resp = 2'b00; timeout = 1'b0;
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
    while (!(aw_done && w_done) && cyc < 20) begin
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      tick(); cyc++;
      pulses |= wr_pulse;
      if (aw_hs) begin aw_done = 1'b1; awvalid = 1'b0; end
      if (w_hs)  begin w_done  = 1'b1; wvalid  = 1'b0; end
    end
    while (!bvalid && cyc < 20) begin tick(); cyc++; pulses |= wr_pulse; end
    if (!bvalid) timeout = 1'b1;
    else resp = bresp;
    awvalid = 1'b0; wvalid = 1'b0;
    bready = 1'b1; tick(); bready = 1'b0;
  endtask

  task automatic axi_read(input logic [7:0] addr, output logic [31:0] data,
                          output logic [1:0] resp, output bit timeout);
    int cyc = 0;
    bit hs;
    data = '0; resp = 2'b00; timeout = 1'b0;
    araddr = addr; arvalid = 1'b1;
    hs = 1'b0;
    while (!hs && cyc < 20) begin
      hs = arready;
      tick(); cyc++;
    end
    arvalid = 1'b0;
    while (!rvalid && cyc < 20) begin tick(); cyc++; end
    if (!rvalid) timeout = 1'b1;
    else begin data = rdata; resp = rresp; end
    rready = 1'b1; tick(); rready = 1'b0;
  endtask

  task automatic test_reset();
    #3 aresetn = 1'b0;
    #10;
    n_checks++;
    if (regs_out[223:0] !== RST_VALS[223:0]) begin
      n_fail++; $display("FAIL reset_regs got %h want %h", regs_out[223:0], RST_VALS[223:0]);
    end
    n_checks++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b11100) begin
      n_fail++; $display("FAIL reset_handshake got %b want 11100", {awready, wready, arready, bvalid, rvalid});
    end
    n_checks++;
    if ({bresp, rresp, rdata, wr_pulse} !== '0) begin
      n_fail++; $display("FAIL reset_outputs got %h want 0", {bresp, rresp, rdata, wr_pulse});
    end
    #10 aresetn = 1'b1;
    tick();
    exp_regs = RST_VALS;
  endtask

  task automatic test_aw_w_same();
    awaddr = 8'h04; wdata = 32'hDEAD_BEEF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    n_checks++;
    if ({wr_pulse, regs_out[63:32], bvalid} !== {8'h02, 32'h1000_0001, 1'b0}) begin
      n_fail++; $display("FAIL t1_exec got pulse=%h reg1=%h bvalid=%b want 02 10000001 0",
                         wr_pulse, regs_out[63:32], bvalid);
    end
    tick();
    exp_regs[63:32] = 32'hDEAD_BEEF;
    n_checks++;
    if ({wr_pulse, regs_out[63:32], bvalid, bresp} !== {8'h00, 32'hDEAD_BEEF, 1'b1, 2'b00}) begin
      n_fail++; $display("FAIL t1_resp got pulse=%h reg1=%h bvalid=%b bresp=%b want 00 deadbeef 1 00",
                         wr_pulse, regs_out[63:32], bvalid, bresp);
    end
    n_checks++;
    if ({awready, wready} !== 2'b00) begin
      n_fail++; $display("FAIL t1_no_accept_in_resp got %b want 00", {awready, wready});
    end
    bready = 1'b1; tick(); bready = 1'b0;
    n_checks++;
    if ({bvalid, awready, wready} !== 3'b011) begin
      n_fail++; $display("FAIL t1_back_idle got %b want 011", {bvalid, awready, wready});
    end
  endtask

  task automatic test_w_first();
    wdata = 32'hAABB_CCDD; wstrb = 4'b0101; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    n_checks++;
    if ({awready, wready} !== 2'b10) begin
      n_fail++; $display("FAIL t2_wait_addr got %b want 10", {awready, wready});
    end
    tick(); tick();
    awaddr = 8'h08; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    n_checks++;
    if ({wr_pulse, regs_out[95:64]} !== {8'h04, 32'h1122_3344}) begin
      n_fail++; $display("FAIL t2_exec got pulse=%h reg2=%h want 04 11223344", wr_pulse, regs_out[95:64]);
    end
    tick();
    exp_regs[95:64] = 32'h11BB_33DD;
    n_checks++;
    if ({regs_out[95:64], bvalid, bresp} !== {32'h11BB_33DD, 1'b1, 2'b00}) begin
      n_fail++; $display("FAIL t2_strobe got reg2=%h bvalid=%b bresp=%b want 11bb33dd 1 00",
                         regs_out[95:64], bvalid, bresp);
    end
    bready = 1'b1; tick(); bready = 1'b0;
  endtask

  task automatic test_aw_first();
    awaddr = 8'h14; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    n_checks++;
    if ({awready, wready} !== 2'b01) begin
      n_fail++; $display("FAIL aw_first_wait_data got %b want 01", {awready, wready});
    end
    tick();
    wdata = 32'h0BAD_F00D; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    tick();
    exp_regs[191:160] = 32'h0BAD_F00D;
    n_checks++;
    if ({regs_out[191:160], bvalid, bresp} !== {32'h0BAD_F00D, 1'b1, 2'b00}) begin
      n_fail++; $display("FAIL aw_first_update got reg5=%h bvalid=%b bresp=%b want 0badf00d 1 00",
                         regs_out[191:160], bvalid, bresp);
    end
    bready = 1'b1; tick(); bready = 1'b0;
  endtask

  task automatic test_out_of_range();
    logic [1:0] resp; logic [7:0] pulses; logic [31:0] data; bit to;
    axi_write(8'h20, 32'hFFFF_FFFF, 4'hF, resp, pulses, to);
    n_checks++;
    if ({to, resp, pulses} !== {1'b0, 2'b10, 8'h00}) begin
      n_fail++; $display("FAIL t3_write got timeout=%b bresp=%b pulse=%h want 0 10 00", to, resp, pulses);
    end
    n_checks++;
    if (regs_out[223:0] !== exp_regs[223:0]) begin
      n_fail++; $display("FAIL t3_no_alias got %h want %h", regs_out[223:0], exp_regs[223:0]);
    end
    axi_read(8'h20, data, resp, to);
    n_checks++;
    if ({to, data, resp} !== {1'b0, 32'h0, 2'b10}) begin
      n_fail++; $display("FAIL t3_read got timeout=%b rdata=%h rresp=%b want 0 00000000 10", to, data, resp);
    end
    axi_read(8'hFC, data, resp, to);
    n_checks++;
    if ({to, data, resp} !== {1'b0, 32'h0, 2'b10}) begin
      n_fail++; $display("FAIL top_addr_read got timeout=%b rdata=%h rresp=%b want 0 00000000 10", to, data, resp);
    end
  endtask

  task automatic test_read_only();
    logic [1:0] resp; logic [7:0] pulses; logic [31:0] data; bit to;
    axi_write(8'h1C, 32'h0000_0000, 4'hF, resp, pulses, to);
    n_checks++;
    if ({to, resp, pulses} !== {1'b0, 2'b10, 8'h00}) begin
      n_fail++; $display("FAIL t4_write got timeout=%b bresp=%b pulse=%h want 0 10 00", to, resp, pulses);
    end
    axi_read(8'h1C, data, resp, to);
    n_checks++;
    if ({to, data, resp} !== {1'b0, 32'h1234_5678, 2'b00}) begin
      n_fail++; $display("FAIL t4_read got timeout=%b rdata=%h rresp=%b want 0 12345678 00", to, data, resp);
    end
    status_in[255:224] = 32'hCAFE_F00D;
    axi_read(8'h1C, data, resp, to);
    n_checks++;
    if ({to, data, resp} !== {1'b0, 32'hCAFE_F00D, 2'b00}) begin
      n_fail++; $display("FAIL ro_live got timeout=%b rdata=%h rresp=%b want 0 cafef00d 00", to, data, resp);
    end
  endtask

  task automatic test_zero_strobe();
    logic [1:0] resp; logic [7:0] pulses; bit to;
    axi_write(8'h10, 32'hFFFF_FFFF, 4'h0, resp, pulses, to);
    n_checks++;
    if ({to, resp, pulses, regs_out[159:128]} !== {1'b0, 2'b00, 8'h10, 32'h1000_0004}) begin
      n_fail++; $display("FAIL zero_strobe got timeout=%b bresp=%b pulse=%h reg4=%h want 0 00 10 10000004",
                         to, resp, pulses, regs_out[159:128]);
    end
  endtask

  task automatic test_read_backpressure();
    araddr = 8'h00; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    n_checks++;
    if ({arready, rvalid} !== 2'b00) begin
      n_fail++; $display("FAIL t5_fetch got arready=%b rvalid=%b want 0 0", arready, rvalid);
    end
    tick();
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({rvalid, arready, rdata, rresp} !== {1'b1, 1'b0, 32'h1000_0000, 2'b00}) begin
        n_fail++; $display("FAIL t5_hold%0d got rvalid=%b arready=%b rdata=%h rresp=%b want 1 0 10000000 00",
                           i, rvalid, arready, rdata, rresp);
      end
      tick();
    end
    rready = 1'b1; tick(); rready = 1'b0;
    n_checks++;
    if ({rvalid, arready} !== 2'b01) begin
      n_fail++; $display("FAIL t5_release got rvalid=%b arready=%b want 0 1", rvalid, arready);
    end
  endtask

  task automatic test_reset_mid_write();
    awaddr = 8'h0C; wdata = 32'h5555_5555; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    n_checks++;
    if ({bvalid, regs_out[127:96]} !== {1'b1, 32'h5555_5555}) begin
      n_fail++; $display("FAIL t6_pre got bvalid=%b reg3=%h want 1 55555555", bvalid, regs_out[127:96]);
    end
    #2 aresetn = 1'b0;
    #1;
    exp_regs = RST_VALS;
    n_checks++;
    if ({bvalid, regs_out[223:0]} !== {1'b0, RST_VALS[223:0]}) begin
      n_fail++; $display("FAIL t6_async got bvalid=%b regs=%h want 0 %h", bvalid, regs_out[223:0], RST_VALS[223:0]);
    end
    #3 aresetn = 1'b1;
    tick();
    n_checks++;
    if ({awready, wready, arready, bvalid} !== 4'b1110) begin
      n_fail++; $display("FAIL t6_release got %b want 1110", {awready, wready, arready, bvalid});
    end
  endtask

  task automatic test_read_write_collision();
    logic [1:0] resp; logic [31:0] data; bit to;
    awaddr = 8'h0C; wdata = 32'h7777_7777; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 8'h0C; arvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    tick();
    n_checks++;
    if ({rvalid, rdata, bvalid, regs_out[127:96]} !== {1'b1, 32'h1000_0003, 1'b1, 32'h7777_7777}) begin
      n_fail++; $display("FAIL collision got rvalid=%b rdata=%h bvalid=%b reg3=%h want 1 10000003 1 77777777",
                         rvalid, rdata, bvalid, regs_out[127:96]);
    end
    bready = 1'b1; rready = 1'b1; tick(); bready = 1'b0; rready = 1'b0;
    axi_read(8'h0C, data, resp, to);
    n_checks++;
    if ({to, data, resp} !== {1'b0, 32'h7777_7777, 2'b00}) begin
      n_fail++; $display("FAIL collision_after got timeout=%b rdata=%h rresp=%b want 0 77777777 00", to, data, resp);
    end
  endtask

  initial begin
    aresetn = 1'b1;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;
    status_in = {32'h1234_5678, 32'hFFFF_0006, 32'hFFFF_0005, 32'hFFFF_0004,
                 32'hFFFF_0003, 32'hFFFF_0002, 32'hFFFF_0001, 32'hFFFF_0000};
    exp_regs = RST_VALS;
    test_reset();
    test_aw_w_same();
    test_w_first();
    test_aw_first();
    test_out_of_range();
    test_read_only();
    test_zero_strobe();
    test_read_backpressure();
    test_reset_mid_write();
    test_read_write_collision();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
